seq_serial_tx: RTL

//  - Frame transmitter: accepts one DATA_W-bit word per valid/ready handshake and shifts it out on a single line.
//  - Frame format: start(0), data bits LSB-first, optional even parity, stop(1).
//  - Transmit end of the serial link whose receiver samples into a registered parallel q.
//  - Sits at the block boundary behind a register stage.

---
 rtl/seq_serial_pkg.sv | 16 +
 rtl/seq_serial_tx_if.sv | 23 ++
 rtl/seq_serial_baud_cnt.sv | 29 ++
 rtl/seq_serial_tx.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/seq_serial_pkg.sv
// Shared types and line levels for the serial frame transmitter.
// States are shared by every build; PARITY is only reachable with SEQ_SERIAL_TX_PARITY_EN.
package seq_serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic TX_IDLE_LEVEL  = 1'b1;
  localparam logic TX_START_LEVEL = 1'b0;

endpackage

// File: rtl/seq_serial_tx_if.sv
// Word handshake between a producer and the serial transmitter.
// The master offers words; the slave (transmitter) drives ready.
interface seq_serial_tx_if #(
  parameter int DATA_W = 8
) ();

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/seq_serial_baud_cnt.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1, tick marks the last cycle.
// Wraps on its own at tick; clr holds it at zero while the line is idle.
module seq_serial_baud_cnt #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] r_cnt;

  assign tick = (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_serial_tx.sv
// Serial frame transmitter: start(0), data LSB-first, [even parity], stop(1).
// Even parity bit is inserted when SEQ_SERIAL_TX_PARITY_EN is defined.
module seq_serial_tx
  import seq_serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_serial_tx_if.slave        s_if,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  tx_state_t         r_state;
  tx_state_t         w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [DATA_W-1:0] w_shift_sr;
  logic [BW-1:0]     r_bit;
  logic [BW-1:0]     w_bit_nxt;
  logic              r_tx;
  logic              w_tx_nxt;
  logic              r_busy;
  logic              r_done;
  logic              w_done_nxt;
  logic              w_clr;
  logic              w_tick;
  logic              w_hs;

  assign s_if.in_ready = (r_state == IDLE) && rst_n;
  assign w_hs          = s_if.in_valid && s_if.in_ready;
  assign w_shift_sr    = r_shift >> 1;

  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;

  seq_serial_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (w_clr),
    .tick (w_tick)
  );

`ifdef SEQ_SERIAL_TX_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par <= 1'b0;
    end else if (w_hs) begin
      r_par <= ^s_if.in_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_tx    <= TX_IDLE_LEVEL;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_bit   <= w_bit_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit;
    w_tx_nxt    = r_tx;
    w_done_nxt  = 1'b0;
    w_clr       = 1'b0;
    unique case (1'b1)
      (r_state == IDLE): begin
        w_clr    = 1'b1;
        w_tx_nxt = TX_IDLE_LEVEL;
        if (w_hs) begin
          w_state_nxt = START;
          w_shift_nxt = s_if.in_data;
          w_tx_nxt    = TX_START_LEVEL;
        end
      end
      (r_state == START): begin
        if (w_tick) begin
          w_state_nxt = DATA;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end
      end
      (r_state == DATA): begin
        if (w_tick) begin
          w_shift_nxt = w_shift_sr;
          if (r_bit == LAST_BIT) begin
`ifdef SEQ_SERIAL_TX_PARITY_EN
            w_state_nxt = PARITY;
            w_tx_nxt    = r_par;
`else
            w_state_nxt = STOP;
            w_tx_nxt    = TX_IDLE_LEVEL;
`endif
          end else begin
            w_bit_nxt = r_bit + 1'b1;
            w_tx_nxt  = w_shift_sr[0];
          end
        end
      end
`ifdef SEQ_SERIAL_TX_PARITY_EN
      (r_state == PARITY): begin
        if (w_tick) begin
          w_state_nxt = STOP;
          w_tx_nxt    = TX_IDLE_LEVEL;
        end
      end
`endif
      (r_state == STOP): begin
        if (w_tick) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
          w_tx_nxt    = TX_IDLE_LEVEL;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = TX_IDLE_LEVEL;
      end
    endcase
  end

endmodule
